// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master between N_REQ clients.
// It launches one frame, waits for finish or the watchdog, then holds a gap before re-arbitrating.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module spi_req_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DW         = `DATA_WIDTH,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 4096,
  parameter int TMR_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic                timeout_err,
  output logic                busy,
  output logic                spi_start,
  output logic [DW-1:0]       spi_data,
  input  logic                spi_finish
);

  // state  | meaning
  // IDLE   | waiting for any req, arbitrates round-robin from r_ptr
  // LAUNCH | spi_start high for one cycle, owner data latched
  // BUSY   | frame in flight, watchdog counting
  // GAP    | enforced idle time so the master can raise ss_n
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_BUSY, S_GAP} state_t;

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [TMR_W-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = (TIMEOUT == 0) ? '0 : TMR_W'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);

  state_t            r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_owner;
  logic [TMR_W-1:0]  r_cnt;
  logic [N_REQ-1:0]  r_gnt;
  logic [N_REQ-1:0]  r_done;
  logic              r_err;
  logic              r_busy;
  logic              r_start;
  logic [DW-1:0]     r_data;

  logic [PW-1:0]     w_win;
  logic [PW-1:0]     w_ptr_nxt;
  logic              w_end_frame;

  // First set request at or after ptr, wrapping; scanning downward lets the nearest one win.
  function automatic logic [PW-1:0] pick(input logic [N_REQ-1:0] rq, input logic [PW-1:0] ptr);
    logic [PW-1:0] win;
    int idx;
    win = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (rq[idx]) win = PW'(idx);
    end
    return win;
  endfunction

  assign w_win       = pick(req, r_ptr);
  assign w_ptr_nxt   = (r_owner == PW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_end_frame = spi_finish || ((TIMEOUT != 0) && (r_cnt == TO_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_data  <= '0;
    end else begin
      r_done <= '0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_owner <= w_win;
            r_gnt   <= ONE << w_win;
            r_data  <= req_data[w_win*DW +: DW];
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_start <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          if (w_end_frame) begin
            // finish has priority over a watchdog hit in the same cycle
            if (spi_finish) r_done <= ONE << r_owner;
            else            r_err  <= 1'b1;
            r_gnt   <= '0;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= '0;
            r_state <= S_GAP;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt >= GAP_LAST) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign done        = r_done;
  assign timeout_err = r_err;
  assign busy        = r_busy;
  assign spi_start   = r_start;
  assign spi_data    = r_data;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: single frame, stray finish, timeout,
// finish/timeout collision, reset mid-frame, data hold and round-robin fairness.
module tb_spi_req_arbiter;
  localparam int N_REQ      = 4;
  localparam int DW         = 8;
  localparam int GAP_CYCLES = 2;
  localparam int TIMEOUT    = 64;
  localparam int TMR_W      = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic                timeout_err;
  logic                busy;
  logic                spi_start;
  logic [DW-1:0]       spi_data;
  logic                spi_finish;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int cyc     = 0;

  spi_req_arbiter #(
    .N_REQ(N_REQ), .DW(DW), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT), .TMR_W(TMR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .timeout_err(timeout_err), .busy(busy),
    .spi_start(spi_start), .spi_data(spi_data), .spi_finish(spi_finish)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 200 && spi_start !== 1'b1; i++) tick();
    chk(tag, 32'(spi_start), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   32'(gnt), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_err"},   32'(timeout_err), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_start"}, 32'(spi_start), 32'd0);
    chk({tag, "_data"},  32'(spi_data), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    int last_done;
    int exp_i;
    logic [DW-1:0] exp_d;

    req = '0; req_data = '0; spi_finish = 1'b0; rst_n = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single frame from requester 1, with data change and req drop while busy
    req_data = 32'h0000_A500; req = 4'b0010;
    tick();
    chk("single_start", 32'(spi_start), 32'd1);
    chk("single_gnt",   32'(gnt), 32'h2);
    chk("single_data",  32'(spi_data), 32'hA5);
    chk("single_busy",  32'(busy), 32'd1);
    tick();
    chk("single_start_pulse", 32'(spi_start), 32'd0);
    tick(); tick();
    req_data = 32'h0000_3C00; req = 4'b0000;
    tick();
    chk("hold_data", 32'(spi_data), 32'hA5);
    chk("hold_gnt",  32'(gnt), 32'h2);
    spi_finish = 1'b1; tick(); spi_finish = 1'b0;
    chk("single_done",     32'(done), 32'h2);
    chk("single_gnt_clr",  32'(gnt), 32'h0);
    chk("single_no_err",   32'(timeout_err), 32'd0);
    tick();
    chk("single_done_pulse", 32'(done), 32'h0);
    chk("gap_busy",          32'(busy), 32'd1);
    tick();
    chk("gap_to_idle", 32'(busy), 32'd0);

    // Stray finish in IDLE
    spi_finish = 1'b1;
    tick(); tick(); tick();
    chk("stray_done",  32'(done), 32'd0);
    chk("stray_err",   32'(timeout_err), 32'd0);
    chk("stray_busy",  32'(busy), 32'd0);
    chk("stray_start", 32'(spi_start), 32'd0);
    spi_finish = 1'b0;

    // Timeout of requester 2 (ptr is 2 after requester 1 finished)
    req = 4'b0100; req_data = 32'h00C3_0000;
    wait_start("to_start");
    chk("to_gnt",  32'(gnt), 32'h4);
    chk("to_data", 32'(spi_data), 32'hC3);
    bad = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      if (done !== '0 || timeout_err !== 1'b0) bad++;
    end
    chk("to_early_pulse", 32'(bad), 32'd0);
    chk("to_gnt_held",    32'(gnt), 32'h4);
    req = 4'b1100; req_data = 32'h5A00_0000;
    tick();
    chk("to_err",     32'(timeout_err), 32'd1);
    chk("to_no_done", 32'(done), 32'd0);
    chk("to_gnt_clr", 32'(gnt), 32'd0);
    tick();
    chk("to_err_pulse", 32'(timeout_err), 32'd0);
    wait_start("next_start");
    chk("next_gnt",  32'(gnt), 32'h8);
    chk("next_data", 32'(spi_data), 32'h5A);

    // Finish and watchdog hit in the same cycle
    for (int i = 0; i < TIMEOUT; i++) tick();
    spi_finish = 1'b1; req = 4'b0000;
    tick(); spi_finish = 1'b0;
    chk("coll_done", 32'(done), 32'h8);
    chk("coll_err",  32'(timeout_err), 32'd0);
    tick();
    chk("coll_err_after", 32'(timeout_err), 32'd0);

    // Move ptr to 2, then reset in the middle of a frame
    req = 4'b0010;
    wait_start("pre_start");
    chk("pre_gnt", 32'(gnt), 32'h2);
    tick(); tick(); tick();
    spi_finish = 1'b1; tick(); spi_finish = 1'b0; req = 4'b0000;
    chk("pre_done", 32'(done), 32'h2);
    req = 4'b0100;
    wait_start("rst_frame_start");
    chk("rst_frame_gnt", 32'(gnt), 32'h4);
    tick(); tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    tick(); tick(); tick();
    chk_all_zero("rst_hold");
    rst_n = 1'b1;
    req = 4'b1001; req_data = 32'h7700_0066;
    wait_start("post_rst_start");
    chk("post_rst_gnt",  32'(gnt), 32'h1);
    chk("post_rst_data", 32'(spi_data), 32'h66);
    tick();
    spi_finish = 1'b1; tick(); spi_finish = 1'b0; req = 4'b0000;
    chk("post_rst_done", 32'(done), 32'h1);

    // Fairness from a clean reset with all four requesting
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    req_data = 32'h4433_2211; req = 4'b1111;
    last_done = 0;
    for (int k = 0; k < 5; k++) begin
      exp_i = k % N_REQ;
      exp_d = req_data[exp_i*DW +: DW];
      wait_start($sformatf("rr%0d_start", k));
      chk($sformatf("rr%0d_gnt", k),  32'(gnt), 32'(4'b0001 << exp_i));
      chk($sformatf("rr%0d_data", k), 32'(spi_data), 32'(exp_d));
      if (k > 0) chk($sformatf("rr%0d_spacing", k), 32'(cyc - last_done >= GAP_CYCLES + 1), 32'd1);
      for (int j = 0; j < 20; j++) tick();
      spi_finish = 1'b1; tick(); spi_finish = 1'b0;
      chk($sformatf("rr%0d_done", k), 32'(done), 32'(4'b0001 << exp_i));
      last_done = cyc;
    end
    req = 4'b0000;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
